// File: rtl/pmbist_march_sequencer_pkg.sv
// Shared definitions for the PMBIST march-element sequencer: instruction layout,
// addressing-mode codes and FSM state encoding.
package pmbist_march_sequencer_pkg;

  localparam int INSTR_W = 22;

  // Bit positions of each field in the scan word, MSB first.
  localparam int UPDWN_BIT = 21;
  localparam int OP_LSB    = 17;
  localparam int POL_LSB   = 13;
  localparam int NO_LSB    = 11;
  localparam int DATA_LSB  = 3;
  localparam int W_BIT     = 2;
  localparam int ADMD_LSB  = 0;

  localparam logic [1:0] ADMD_ALL    = 2'd0;
  localparam logic [1:0] ADMD_EVEN   = 2'd1;
  localparam logic [1:0] ADMD_ODD    = 2'd2;
  localparam logic [1:0] ADMD_SINGLE = 2'd3;

  // Packed so the struct layout matches the bit positions above exactly.
  typedef struct packed {
    logic       updwn;
    logic [3:0] op;
    logic [3:0] pol;
    logic [1:0] no;
    logic [7:0] data;
    logic       w;
    logic [1:0] admd;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/pmbist_march_sequencer_addr_gen.sv
// March address generator: walks the tested address range up or down with a
// stride set by the addressing mode, flagging the final address of the walk.
module pmbist_addr_gen
  import pmbist_march_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              updwn_i,
  input  logic [1:0]        admd_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int HI_ALL_I  = DEPTH - 1;
  localparam int HI_EVEN_I = ((DEPTH - 1) / 2) * 2;
  localparam int HI_ODD_I  = (((DEPTH - 1) % 2) == 1) ? (DEPTH - 1) : (DEPTH - 2);

  localparam logic [ADDR_W-1:0] HI_ALL  = ADDR_W'(HI_ALL_I);
  localparam logic [ADDR_W-1:0] HI_EVEN = ADDR_W'(HI_EVEN_I);
  localparam logic [ADDR_W-1:0] HI_ODD  = ADDR_W'(HI_ODD_I);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] lo, hi, inc, first, final_addr;

  always_comb begin
    lo  = '0;
    hi  = '0;
    inc = ADDR_W'(1);
    case (admd_i)
      ADMD_ALL:  begin lo = '0;          hi = HI_ALL;  inc = ADDR_W'(1); end
      ADMD_EVEN: begin lo = '0;          hi = HI_EVEN; inc = ADDR_W'(2); end
      ADMD_ODD:  begin lo = ADDR_W'(1);  hi = HI_ODD;  inc = ADDR_W'(2); end
      default:   begin lo = '0;          hi = '0;      inc = ADDR_W'(1); end
    endcase
    first      = updwn_i ? hi : lo;
    final_addr = updwn_i ? lo : hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (load_i) begin
      addr_q <= first;
    end else if (step_i) begin
      addr_q <= updwn_i ? (addr_q - inc) : (addr_q + inc);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (addr_q == final_addr);

endmodule

// File: rtl/pmbist_march_sequencer.sv
// Executes one march element against a single-port SRAM: sequences addresses and
// ops, drives polarity-adjusted background data and checks read data one cycle later.
module pmbist_march_sequencer
  import pmbist_march_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ts,
  input  logic [INSTR_W-1:0] scan,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               passfail,
  output logic [ADDR_W-1:0]  fail_addr
);

  state_e            state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [1:0]        op_q, op_d;
  logic              accept;
  logic              gen_load, gen_step, gen_last;
  logic [ADDR_W-1:0] gen_addr;

  logic              mem_en_q, mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              busy_q, done_q, passfail_q;
  logic [ADDR_W-1:0] fail_addr_q;

  logic              cmp_vld_q;
  logic [DATA_W-1:0] cmp_exp_q;
  logic [ADDR_W-1:0] cmp_addr_q;

  function automatic logic [DATA_W-1:0] pattern(input instr_t ins, input logic [1:0] k);
    return {(DATA_W/8){ins.data ^ {8{ins.pol[k]}}}};
  endfunction

  pmbist_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load_i  (gen_load),
    .step_i  (gen_step),
    .updwn_i (instr_d.updwn),
    .admd_i  (instr_d.admd),
    .addr_o  (gen_addr),
    .last_o  (gen_last)
  );

  assign accept = (state_q == ST_IDLE) && ts;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    op_d     = op_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ts) begin
          state_d  = ST_RUN;
          instr_d  = instr_t'(scan);
          op_d     = 2'd0;
          gen_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (op_q == instr_q.no) begin
          op_d = 2'd0;
          if (gen_last) begin
            state_d = ST_DRAIN;
          end else begin
            gen_step = 1'b1;
            state_d  = instr_q.w ? ST_WAIT : ST_RUN;
          end
        end else begin
          op_d = op_q + 2'd1;
        end
      end
      ST_WAIT:  state_d = ST_RUN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory strobes are registered from next-state so they line up with gen_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      passfail_q  <= 1'b1;
      fail_addr_q <= '0;
      cmp_vld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mem_en_q <= (state_d == ST_RUN);
      mem_we_q <= (state_d == ST_RUN) && instr_d.op[op_d];
      if (state_d == ST_RUN) mem_wdata_q <= pattern(instr_d, op_d);
      busy_q    <= (state_d == ST_RUN) || (state_d == ST_WAIT) || (state_d == ST_DRAIN);
      done_q    <= (state_d == ST_DONE);
      cmp_vld_q <= mem_en_q && !mem_we_q;
      if (accept) begin
        passfail_q  <= 1'b1;
        fail_addr_q <= '0;
      end else if (cmp_vld_q && (mem_rdata != cmp_exp_q)) begin
        passfail_q <= 1'b0;
        if (passfail_q) fail_addr_q <= cmp_addr_q;
      end
    end
  end

  // Datapath registers carry no reset; their use is qualified by state/cmp_vld_q.
  always_ff @(posedge clk) begin
    instr_q    <= instr_d;
    cmp_exp_q  <= mem_wdata_q;
    cmp_addr_q <= gen_addr;
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = gen_addr;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign passfail  = passfail_q;
  assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_pmbist_march_sequencer.sv
// Bench for pmbist_march_sequencer: behavioural SRAM with stuck-at faults and an
// access-list reference model derived from the march-element rules.
module tb_pmbist_march_sequencer;
  import pmbist_march_sequencer_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ts  = 1'b0;
  logic [INSTR_W-1:0] scan = '0;
  logic               mem_en, mem_we, busy, done, passfail;
  logic [ADDR_W-1:0]  mem_addr, fail_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  pmbist_march_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ts(ts), .scan(scan),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .passfail(passfail),
    .fail_addr(fail_addr)
  );

  always #5 clk = ~clk;

  // Memory under test: stuck-at-1 on bit 0 at up to two addresses.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int fa0 = -1;
  int fa1 = -1;
  logic init_go = 1'b0;

  function automatic logic [DATA_W-1:0] faulty(input int a, input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = w;
    if (a == fa0 || a == fa1) r[0] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'($urandom);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= faulty(int'(mem_addr), mem[mem_addr]);
    end
  end

  typedef struct {
    bit                we;
    int                addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } acc_t;

  acc_t exp_q[$];
  acc_t got_q[$];
  int   exp_lat;
  logic exp_pf;
  int   exp_fa;

  // Reference: enumerate the visited addresses, expand ops, replay on a copy of memory.
  task automatic build_ref(input instr_t ins);
    int addrs[$];
    int lo, hi, st, n, nops, per;
    logic [DATA_W-1:0] d;
    case (ins.admd)
      2'd0:    begin lo = 0; hi = DEPTH - 1; st = 1; end
      2'd1:    begin lo = 0; hi = (DEPTH - 1) - ((DEPTH - 1) % 2); st = 2; end
      2'd2:    begin lo = 1; hi = ((DEPTH - 1) % 2 == 1) ? DEPTH - 1 : DEPTH - 2; st = 2; end
      default: begin lo = 0; hi = 0; st = 1; end
    endcase
    for (int a = lo; a <= hi; a += st) addrs.push_back(a);
    if (ins.updwn) addrs.reverse();
    n    = addrs.size();
    nops = int'(ins.no) + 1;
    per  = nops + (ins.w ? 1 : 0);
    ref_mem = mem;
    exp_q.delete();
    exp_pf = 1'b1;
    exp_fa = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < nops; k++) begin
        d = {(DATA_W/8){ins.data ^ {8{ins.pol[k]}}}};
        exp_q.push_back('{ins.op[k], addrs[i], d, 1 + i * per + k});
        if (ins.op[k]) ref_mem[addrs[i]] = d;
        else if (faulty(addrs[i], ref_mem[addrs[i]]) !== d) begin
          if (exp_pf) exp_fa = addrs[i];
          exp_pf = 1'b0;
        end
      end
    end
    exp_lat = n * nops + (ins.w ? n - 1 : 0) + 2;
  endtask

  task automatic init_mem();
    @(negedge clk); init_go = 1'b1;
    @(negedge clk); init_go = 1'b0;
  endtask

  task automatic run_instr(input instr_t ins, input int glitch_k, input bit ts_at_done,
                           input string name);
    int lat, busy_cnt, nprint, n;
    bit busy_done;
    logic pf;
    logic [ADDR_W-1:0] fa;
    build_ref(ins);
    got_q.delete();
    lat = -1; busy_cnt = 0; busy_done = 1'b0; pf = 1'bx; fa = 'x; nprint = 0;
    @(negedge clk); scan = ins; ts = 1'b1;
    for (int k = 1; k <= exp_lat + 20; k++) begin
      @(negedge clk);
      ts = 1'b0;
      if (mem_en) got_q.push_back('{mem_we, int'(mem_addr), mem_wdata, k});
      if (busy) busy_cnt++;
      if (done) begin
        lat = k; pf = passfail; fa = fail_addr; busy_done = busy; ts = ts_at_done;
        break;
      end
      if (k == glitch_k) ts = 1'b1;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s access count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i].we !== exp_q[i].we || got_q[i].addr !== exp_q[i].addr ||
          got_q[i].data !== exp_q[i].data || got_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        if (nprint < 4)
          $display("FAIL %s access %0d: got we=%0b a=%0h d=%0h c=%0d expected we=%0b a=%0h d=%0h c=%0d",
                   name, i, got_q[i].we, got_q[i].addr, got_q[i].data, got_q[i].cyc,
                   exp_q[i].we, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
        nprint++;
      end
    end
    checks++;
    if (pf !== exp_pf) begin
      errors++; $display("FAIL %s passfail: got %0b expected %0b", name, pf, exp_pf);
    end
    checks++;
    if (fa !== ADDR_W'(exp_fa)) begin
      errors++; $display("FAIL %s fail_addr: got %0h expected %0h", name, fa, exp_fa);
    end
    checks++;
    if (busy_cnt !== exp_lat - 1 || busy_done !== 1'b0) begin
      errors++; $display("FAIL %s busy: got %0d cycles (at done %0b) expected %0d (0)",
                         name, busy_cnt, busy_done, exp_lat - 1);
    end
    @(negedge clk);
    ts = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL %s after done: got done=%0b busy=%0b mem_en=%0b expected 0 0 0",
                         name, done, busy, mem_en);
    end
    checks++;
    if (passfail !== exp_pf || fail_addr !== ADDR_W'(exp_fa)) begin
      errors++; $display("FAIL %s hold: got pf=%0b fa=%0h expected pf=%0b fa=%0h",
                         name, passfail, fail_addr, exp_pf, exp_fa);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || passfail !== 1'b1 || fail_addr !== '0) begin
      errors++;
      $display("FAIL %s: got en=%0b we=%0b a=%0h d=%0h busy=%0b done=%0b pf=%0b fa=%0h expected 0 0 0 0 0 0 1 0",
               name, mem_en, mem_we, mem_addr, mem_wdata, busy, done, passfail, fail_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_single_addr();
    instr_t ins;
    ins = '0;
    ins.admd = ADMD_SINGLE; ins.no = 2'd3; ins.op = 4'b0101; ins.pol = 4'b0011;
    ins.data = 8'hFA;
    run_instr(ins, 0, 1'b0, "single_addr");
  endtask

  task automatic test_full_ascending();
    instr_t ins;
    ins = '0;
    ins.admd = ADMD_ALL; ins.no = 2'd1; ins.op = 4'b0001; ins.data = 8'h55;
    run_instr(ins, 0, 1'b0, "full_ascending");
  endtask

  task automatic test_descending_wait();
    instr_t ins;
    ins = '0;
    ins.updwn = 1'b1; ins.admd = ADMD_EVEN; ins.w = 1'b1; ins.no = 2'd0;
    ins.op = 4'b0001; ins.data = 8'h3C;
    run_instr(ins, 0, 1'b0, "descending_wait");
    ins.admd = ADMD_ODD; ins.updwn = 1'b0; ins.pol = 4'b0001; ins.w = 1'b0;
    run_instr(ins, 0, 1'b0, "odd_ascending");
  endtask

  task automatic test_stuck_at();
    instr_t ins;
    ins = '0;
    ins.admd = ADMD_ALL; ins.no = 2'd1; ins.op = 4'b0001; ins.data = 8'hAA;
    fa0 = 'h21; fa1 = 'h80;
    run_instr(ins, 0, 1'b0, "stuck_at");
    checks++;
    if (passfail !== 1'b0 || fail_addr !== 8'h21) begin
      errors++; $display("FAIL stuck_at_first: got pf=%0b fa=%0h expected pf=0 fa=21", passfail, fail_addr);
    end
  endtask

  task automatic test_ts_ignored();
    instr_t ins;
    ins = '0;
    ins.admd = ADMD_ALL; ins.no = 2'd1; ins.op = 4'b0001; ins.data = 8'hAA;
    run_instr(ins, 37, 1'b1, "ts_mid_run");
    fa0 = -1; fa1 = -1;
    ins.data = 8'h0F; ins.updwn = 1'b1;
    run_instr(ins, 100, 1'b0, "rearm");
    checks++;
    if (passfail !== 1'b1) begin
      errors++; $display("FAIL rearm_pass: got %0b expected 1", passfail);
    end
  endtask

  task automatic test_mid_reset();
    instr_t ins;
    ins = '0;
    ins.admd = ADMD_ALL; ins.no = 2'd1; ins.op = 4'b0001; ins.data = 8'hAA;
    fa0 = 2;
    @(negedge clk); scan = ins; ts = 1'b1;
    @(negedge clk); ts = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (passfail !== 1'b0 || busy !== 1'b1 || mem_en !== 1'b1) begin
      errors++; $display("FAIL mid_reset_pre: got pf=%0b busy=%0b en=%0b expected 0 1 1",
                         passfail, busy, mem_en);
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("mid_reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("after_mid_reset");
    fa0 = -1;
    ins.no = 2'd2; ins.op = 4'b0101; ins.pol = 4'b0110; ins.data = 8'hC3;
    run_instr(ins, 0, 1'b0, "restart");
  endtask

  task automatic test_random();
    instr_t ins;
    for (int it = 0; it < 8; it++) begin
      if (it % 3 == 0) init_mem();
      ins = instr_t'(INSTR_W'($urandom));
      fa0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DEPTH - 1)) : -1;
      fa1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DEPTH - 1)) : -1;
      run_instr(ins, int'($urandom_range(2, 200)), 1'($urandom_range(0, 1)),
                $sformatf("random%0d", it));
    end
    fa0 = -1; fa1 = -1;
  endtask

  initial begin
    test_reset();
    init_mem();
    test_single_addr();
    test_full_ascending();
    test_descending_wait();
    test_stuck_at();
    test_ts_ignored();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
